// File: rtl/addsub_bcd_pkg.sv
// Shared definitions for the add/subtract to BCD seven-segment display block.
//   state_t    : controller state encoding (IDLE, CONV, DONE)
//   SEG_BLANK  : all segments off (active-low)
//   SEG_MINUS  : only segment g lit (active-low)
//   SEG_TABLE  : hex digit to active-low segment pattern, bit 0 = a .. bit 6 = g
//   bcd_adjust : double-dabble nibble correction (add 3 when >= 5)
package addsub_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  // Entry n sits at index n (the concatenation lists F first, 0 last).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-seven-segment decoder.
//   code_i : 4-bit digit code
//   seg_o  : 7-bit active-low segment pattern, bit 0 = a .. bit 6 = g
module seg7_decode
  import addsub_bcd_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[code_i];

endmodule

// File: rtl/addsub_bcd_seg.sv
// Unsigned adder/subtractor whose result is converted to BCD by a sequential
// double-dabble engine and shown on seven-segment displays with a sign digit.
//   clk_i, rst_i : clock, synchronous active-high reset
//   a_i, b_i     : unsigned operands (WIDTH bits)
//   cin_i        : carry-in (add) / borrow-in (subtract)
//   mode_i       : 0 = A+B+cin, 1 = A-B-cin
//   blank_i      : leading-zero blanking enable (sampled when results load)
//   start_i      : begin an operation (ignored while busy_o)
//   busy_o       : operation in progress
//   valid_o      : one-cycle pulse when new results reach the displays
//   cout_o       : carry/borrow of the last completed result
//   sign_o       : minus pattern for a negative result, else blank
//   seg_o        : DIGITS magnitude displays, digit k on bits 7k+6..7k
module addsub_bcd_seg
  import addsub_bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WIDTH-1:0]      a_i,
  input  logic [WIDTH-1:0]      b_i,
  input  logic                  cin_i,
  input  logic                  mode_i,
  input  logic                  blank_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic                  cout_o,
  output logic [6:0]            sign_o,
  output logic [7*DIGITS-1:0]   seg_o
);

  localparam int R  = WIDTH + 1;
  localparam int CW = $clog2(R + 1);
  localparam int BW = 4 * DIGITS;

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("addsub_bcd_seg: WIDTH must be in 2..16");
  end
  if ((10 ** DIGITS) < (2 ** (WIDTH + 1))) begin : g_bad_digits
    $error("addsub_bcd_seg: DIGITS too small for WIDTH+1 bit magnitude");
  end

  state_t r_state;
  state_t w_state_next;

  logic [R-1:0]        r_bin;
  logic [BW-1:0]       r_bcd;
  logic [CW-1:0]       r_cnt;
  logic                r_neg;
  logic                r_cy;
  logic                r_valid;
  logic                r_cout;
  logic [6:0]          r_sign;
  logic [7*DIGITS-1:0] r_seg;

  logic                w_load;
  logic                w_shift;
  logic                w_done;

  logic [R-1:0]        w_sum;
  logic [R-1:0]        w_bsum;
  logic [R-1:0]        w_diff;
  logic                w_lt;
  logic [R-1:0]        w_mag;
  logic                w_neg;
  logic                w_cy;

  logic [BW-1:0]       w_bcd_adj;
  logic [7*DIGITS-1:0] w_dig_seg;
  logic [7*DIGITS-1:0] w_seg_next;
  logic                w_lz;

  // Controller
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_load       = 1'b1;
          w_state_next = ST_CONV;
        end
      end
      ST_CONV: begin
        w_shift = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Arithmetic: result is formed at WIDTH+1 bits so both the carry and the
  // full negative range of a difference are representable.
  always_comb begin
    w_sum  = {1'b0, a_i} + {1'b0, b_i} + R'(cin_i);
    w_bsum = {1'b0, b_i} + R'(cin_i);
    w_diff = {1'b0, a_i} - w_bsum;
    w_lt   = ({1'b0, a_i} < w_bsum);
    if (mode_i) begin
      w_mag = w_lt ? ('0 - w_diff) : w_diff;
      w_neg = w_lt;
      w_cy  = w_lt;
    end else begin
      w_mag = w_sum;
      w_neg = 1'b0;
      w_cy  = w_sum[WIDTH];
    end
  end

  // Double-dabble correction applied before every shift
  always_comb begin
    w_bcd_adj = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      w_bcd_adj[4*i +: 4] = bcd_adjust(r_bcd[4*i +: 4]);
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_dec
    seg7_decode u_dec (
      .code_i (r_bcd[4*k +: 4]),
      .seg_o  (w_dig_seg[7*k +: 7])
    );
  end

  // Scan from the most significant digit down; a digit is blanked while all
  // digits at and above it are zero. Digit 0 is never blanked.
  always_comb begin
    w_seg_next = w_dig_seg;
    w_lz       = 1'b1;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      if (r_bcd[4*(DIGITS-1-j) +: 4] != 4'd0) begin
        w_lz = 1'b0;
      end
      if (blank_i && w_lz && (j != DIGITS - 1)) begin
        w_seg_next[7*(DIGITS-1-j) +: 7] = SEG_BLANK;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_cy    <= 1'b0;
      r_valid <= 1'b0;
      r_cout  <= 1'b0;
      r_sign  <= SEG_BLANK;
      r_seg   <= {DIGITS{SEG_BLANK}};
    end else begin
      r_valid <= 1'b0;
      if (w_load) begin
        r_bin <= w_mag;
        r_neg <= w_neg;
        r_cy  <= w_cy;
        r_bcd <= '0;
        r_cnt <= CW'(R);
      end
      if (w_shift) begin
        r_bcd <= {w_bcd_adj[BW-2:0], r_bin[R-1]};
        r_bin <= {r_bin[R-2:0], 1'b0};
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_done) begin
        r_seg   <= w_seg_next;
        r_sign  <= r_neg ? SEG_MINUS : SEG_BLANK;
        r_cout  <= r_cy;
        r_valid <= 1'b1;
      end
    end
  end

  assign busy_o  = (r_state != ST_IDLE);
  assign valid_o = r_valid;
  assign cout_o  = r_cout;
  assign sign_o  = r_sign;
  assign seg_o   = r_seg;

endmodule

// File: doc/addsub_bcd_seg.md
ADDSUB_BCD_SEG -- requirements
Module: addsub_bcd_seg

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits, legal range 2..16.
REQ-002 Parameter DIGITS, default 3, number of decimal magnitude digits driven; elaboration SHALL fail if 10**DIGITS < 2**(WIDTH+1).
REQ-003 clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 a_i  input  WIDTH  operand A, unsigned.
REQ-006 b_i  input  WIDTH  operand B, unsigned.
REQ-007 cin_i  input  1  carry-in (add) / borrow-in (subtract).
REQ-008 mode_i  input  1  0 = A+B+cin, 1 = A-B-cin.
REQ-009 blank_i  input  1  1 = leading-zero blanking enabled.
REQ-010 start_i  input  1  request: capture operands and begin operation.
REQ-011 busy_o  output  1  high while an operation is in progress.
REQ-012 valid_o  output  1  one-cycle pulse when a new result is on the displays.
REQ-013 cout_o  output  1  registered carry-out (add) or borrow-out (subtract) of the last completed result.
REQ-014 sign_o  output  7  sign display: minus pattern if last result negative, else blank.
REQ-015 seg_o  output  7*DIGITS  magnitude displays; digit k (k=0 least significant) on bits 7k+6..7k.

Function
REQ-016 All segment patterns SHALL be active-low, bit 0 = segment a through bit 6 = segment g; blank = all ones; minus = segment g only lit.
REQ-017 State machine states SHALL be IDLE, CONV, DONE.
REQ-018 In IDLE with start_i=1: capture magnitude of the arithmetic result (R = WIDTH+1 bits) into the shift register, capture sign and carry/borrow, clear BCD register, load counter with R, go to CONV.
REQ-019 Add: result = a_i+b_i+cin_i; sign = 0; carry = bit WIDTH of result.
REQ-020 Subtract: difference = a_i-b_i-cin_i in WIDTH+1 bit two's complement; borrow = sign = 1 when a_i < b_i+cin_i; magnitude = absolute value.
REQ-021 CONV: each cycle, every BCD nibble >= 5 SHALL be incremented by 3, then BCD and binary registers shift left one as a unit; counter decrements; after R such cycles go to DONE.
REQ-022 DONE: update seg_o, sign_o, cout_o from the converted value in one cycle, assert valid_o for that cycle only, return to IDLE.
REQ-023 Latency: start_i accepted at edge t, valid_o high during cycle t+R+1 (t+10 at defaults).
REQ-024 busy_o SHALL be high in CONV and DONE, low in IDLE.
REQ-025 start_i while busy_o=1 SHALL be ignored; operands changing during CONV SHALL not affect the result.
REQ-026 start_i held high SHALL start a new operation on the first IDLE cycle after DONE.
REQ-027 Blanking: with blank_i=1, digits above the most significant non-zero digit SHALL be blank; digit 0 SHALL always be shown (zero displays as single "0"); blank_i sampled in DONE.
REQ-028 seg_o, sign_o, cout_o SHALL hold the last completed result until the next DONE.

Reset
REQ-029 rst_i=1 at an edge SHALL force state IDLE, busy_o=0, valid_o=0, cout_o=0, sign_o blank, all seg_o digits blank, shift/BCD registers and counter to 0.
REQ-030 Reset during CONV or DONE SHALL abort the operation with no valid_o pulse; reset has priority over start_i.

Structure
REQ-031 Shared package addsub_bcd_pkg SHALL hold the state enumeration, SEG_BLANK, SEG_MINUS and the 16-entry hex-to-segment constant table.
REQ-032 One sub-module seg7_decode (4-bit code in, 7-bit active-low pattern out, combinational) SHALL be instantiated DIGITS times.
REQ-033 The adder/subtractor and double-dabble datapath SHALL be inline in addsub_bcd_seg.

Verification
REQ-034 WIDTH=8: a=200, b=100, cin=1, mode=0, start -> valid_o at t+10, digits 3,0,1, cout_o=1, sign blank.
REQ-035 a=5, b=9, cin=0, mode=1, blank_i=1 -> digits blank,blank,4, sign minus, cout_o=1.
REQ-036 a=255, b=255, cin=1, mode=0 -> digits 5,1,1, cout_o=1; a=0, b=0, cin=0, blank_i=1 -> single "0", others blank.
REQ-037 start pulsed at t+3 during a conversion with different operands -> ignored, first result unchanged, exactly one valid_o pulse.
REQ-038 rst_i asserted at t+5 of a conversion -> no valid_o, all displays blank, busy_o=0 next cycle; subsequent start completes normally.
